// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single mainMem port between the fetch (read-only) and data
// (read/write) requesters, sequencing single/burst transfers and rejecting bad addresses.
module mem_arbiter #(
   parameter logic [0:31] BASE_ADDR    = 32'h80020000,
   parameter int          MEM_WORDS    = 262144,
   parameter int          READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        f_req,
   input  logic [0:31] f_addr,
   input  logic [0:1]  f_acc_size,
   output logic        f_ack,
   output logic        f_err,
   output logic        f_rvalid,
   output logic [0:31] f_rdata,
   output logic        f_done,
   input  logic        d_req,
   input  logic        d_wren,
   input  logic [0:31] d_addr,
   input  logic [0:1]  d_acc_size,
   input  logic [0:31] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic        d_wready,
   output logic        d_rvalid,
   output logic [0:31] d_rdata,
   output logic        d_done,
   output logic [0:31] mem_addr,
   output logic [0:31] mem_data_in,
   output logic [0:1]  mem_acc_size,
   output logic        mem_wren,
   output logic        mem_enable,
   input  logic [0:31] mem_data_out,
   input  logic        mem_busy
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_WAIT, READ, DONE} state_t;

   state_t      state, state_next;
   logic [4:0]  cnt;
   logic        last_d;
   logic        cur_d;
   logic        pick_d;
   logic [0:31] pick_addr;
   logic [0:1]  pick_size;
   logic        arb, grant, reject, beat_last;

   function automatic logic [4:0] last_beat(input logic [0:1] s);
      case (s)
         2'd0:    return 5'd0;
         2'd1:    return 5'd3;
         2'd2:    return 5'd7;
         default: return 5'd15;
      endcase
   endfunction

   function automatic logic addr_ok(input logic [0:31] a, input logic [0:1] s);
      logic [33:0] span, top;
      span = (34'(last_beat(s)) + 34'd1) << 2;
      top  = 34'(BASE_ADDR) + 34'(MEM_WORDS) * 34'd4;
      return (a[30:31] == 2'b00) && (a >= BASE_ADDR) && (34'(a) + span <= top);
   endfunction

   // Round-robin winner; arbitration is held off while an err pulse is still out so a
   // rejected requester gets a cycle to withdraw before it could be sampled again.
   assign pick_d    = d_req && (!f_req || !last_d);
   assign pick_addr = pick_d ? d_addr : f_addr;
   assign pick_size = pick_d ? d_acc_size : f_acc_size;
   assign arb       = (state == IDLE) && !mem_busy && !f_err && !d_err && (f_req || d_req);
   assign grant     = arb && addr_ok(pick_addr, pick_size);
   assign reject    = arb && !grant;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (grant) begin
               if (pick_d && d_wren)   state_next = WRITE;
               else if (READ_LATENCY > 0) state_next = RD_WAIT;
               else                    state_next = READ;
            end
         WRITE:   if (cnt == last_beat(mem_acc_size)) state_next = DONE;
         RD_WAIT: if (cnt == 5'(READ_LATENCY - 1))    state_next = READ;
         READ:    if (cnt == last_beat(mem_acc_size)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      beat_last   = (cnt == last_beat(mem_acc_size));
      mem_wren    = (state == WRITE);
      d_wready    = mem_wren;
      mem_data_in = mem_wren ? d_wdata : '0;
      f_rvalid    = (state == READ) && !cur_d;
      d_rvalid    = (state == READ) && cur_d;
      f_rdata     = f_rvalid ? mem_data_out : '0;
      d_rdata     = d_rvalid ? mem_data_out : '0;
      f_done      = f_rvalid && beat_last;
      d_done      = (mem_wren || d_rvalid) && beat_last;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         last_d       <= 1'b0;
         cur_d        <= 1'b0;
         mem_addr     <= '0;
         mem_acc_size <= '0;
         mem_enable   <= 1'b0;
         f_ack        <= 1'b0;
         f_err        <= 1'b0;
         d_ack        <= 1'b0;
         d_err        <= 1'b0;
      end else begin
         mem_enable <= 1'b1;
         f_ack      <= grant && !pick_d;
         d_ack      <= grant && pick_d;
         f_err      <= reject && !pick_d;
         d_err      <= reject && pick_d;
         if (grant) begin
            last_d       <= pick_d;
            cur_d        <= pick_d;
            mem_addr     <= pick_addr;
            mem_acc_size <= pick_size;
         end
         // Counter restarts on every state change: wait cycles, then beats.
         if (state_next != state)                 cnt <= '0;
         else if (state != IDLE && state != DONE) cnt <= cnt + 5'd1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts every handshake,
// beat and completion with its cycle; a monitor compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam logic [31:0] BASE  = 32'h80020000;
   localparam int          WORDS = 262144;
   localparam int          LAT   = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        f_req = 1'b0;
   logic [31:0] f_addr = '0;
   logic [1:0]  f_acc_size = '0;
   logic        f_ack, f_err, f_rvalid, f_done;
   logic [31:0] f_rdata;
   logic        d_req = 1'b0;
   logic        d_wren = 1'b0;
   logic [31:0] d_addr = '0;
   logic [1:0]  d_acc_size = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack, d_err, d_wready, d_rvalid, d_done;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr, mem_data_in;
   logic [1:0]  mem_acc_size;
   logic        mem_wren, mem_enable;
   logic [31:0] mem_data_out = '0;
   logic        mem_busy = 1'b0;

   mem_arbiter #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .READ_LATENCY(LAT)) dut (
      .clock(clock), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_acc_size(f_acc_size),
      .f_ack(f_ack), .f_err(f_err), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_done(f_done),
      .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_acc_size(d_acc_size), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_wready(d_wready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_done(d_done),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_acc_size(mem_acc_size),
      .mem_wren(mem_wren), .mem_enable(mem_enable),
      .mem_data_out(mem_data_out), .mem_busy(mem_busy)
   );

   always #5 clock = ~clock;

   typedef struct { int cyc; int code; logic [31:0] data; } ev_t;
   ev_t         exp_q[$];
   logic [31:0] wbuf[$];
   logic [31:0] ref_mem [int];
   logic [31:0] sim_mem [int];
   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   bit          last_d_m = 1'b0;
   logic [31:0] last_acc = '0;
   logic [31:0] exp_waddr = '0;
   int          wbeat = 0;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic string evname(input int c);
      case (c)
         0: return "f_ack";    1: return "f_err";    3: return "f_rvalid"; 4: return "f_done";
         5: return "d_ack";    6: return "d_err";    7: return "d_wready"; 8: return "d_rvalid";
         9: return "d_done";   default: return "none";
      endcase
   endfunction

   function automatic int beats(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (1 << (int'(s) + 1));
   endfunction

   function automatic bit addr_ok(input logic [31:0] a, input logic [1:0] s);
      longint lo, hi, aa;
      lo = {32'd0, BASE};
      hi = lo + 4 * longint'(WORDS);
      aa = {32'd0, a};
      return (a[1:0] == 2'b00) && (aa >= lo) && (aa + 4 * beats(s) <= hi);
   endfunction

   function automatic logic [31:0] init_word(input int idx);
      return 32'h5EED0000 ^ (idx * 32'h01000193);
   endfunction

   function automatic logic [31:0] ref_word(input int idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
   endfunction

   function automatic void push(input int c, input int code, input logic [31:0] d);
      ev_t e;
      e.cyc = c; e.code = code; e.data = d;
      exp_q.push_back(e);
   endfunction

   // Queues every event one request produces when sampled at the end of cycle t;
   // returns the next cycle in which the arbiter can sample a request.
   function automatic int predict(input bit is_d, input bit wr, input int t,
                                  input logic [31:0] a, input logic [1:0] s);
      int n, b, idx;
      n = beats(s);
      b = is_d ? 5 : 0;
      if (!addr_ok(a, s)) begin
         push(t + 1, b + 1, '0);
         return t + 2;
      end
      last_d_m = is_d;
      last_acc = a;
      idx = int'((a - BASE) >> 2);
      push(t + 1, b, '0);
      if (wr) begin
         for (int k = 0; k < n; k++) begin
            if (k != 0) begin end
            push(t + 1 + k, 7, wbuf[k]);
            ref_mem[idx + k] = wbuf[k];
            if (k == n - 1) push(t + 1 + k, 9, '0);
         end
         return t + n + 2;
      end
      for (int k = 0; k < n; k++) begin
         push(t + LAT + 1 + k, b + 3, ref_word(idx + k));
         if (k == n - 1) push(t + LAT + 1 + k, b + 4, '0);
      end
      return t + LAT + n + 2;
   endfunction

   // Memory: stores write beats in order from the held address, returns read beats
   // LAT cycles after the read command and junk otherwise.
   int wcnt = 0;
   always @(negedge clock) begin
      if (reset_n && mem_wren) begin
         sim_mem[int'((mem_addr - BASE) >> 2) + wcnt] = mem_data_in;
         wcnt++;
      end else wcnt = 0;
   end

   int          rd_start = -100;
   int          rd_n = 0;
   int          rd_idx = 0;
   initial forever begin
      @(posedge clock); #1;
      if (!reset_n) rd_start = -100;
      else if ((f_ack || d_ack) && !mem_wren) begin
         rd_start = cyc;
         rd_idx   = int'((mem_addr - BASE) >> 2);
         rd_n     = beats(mem_acc_size);
      end
      if (reset_n && cyc >= rd_start + LAT && cyc < rd_start + LAT + rd_n) begin
         if (sim_mem.exists(rd_idx + cyc - rd_start - LAT)) mem_data_out = sim_mem[rd_idx + cyc - rd_start - LAT];
         else mem_data_out = init_word(rd_idx + cyc - rd_start - LAT);
      end else mem_data_out = $urandom;
   end

   initial forever begin
      @(posedge clock); #1;
      if (d_wready) begin
         d_wdata = (wbeat < wbuf.size()) ? wbuf[wbeat] : 32'hDEADBEEF;
         wbeat++;
      end else d_wdata = $urandom;
   end

   logic [9:0]  ev;
   logic [31:0] evd [10];
   ev_t         got;
   always @(negedge clock) begin
      if (reset_n) begin
         ev = {d_done, d_rvalid, d_wready, d_err, d_ack, f_done, f_rvalid, 1'b0, f_err, f_ack};
         for (int c = 0; c < 10; c++) evd[c] = '0;
         evd[3] = f_rdata; evd[7] = mem_data_in; evd[8] = d_rdata;
         for (int c = 0; c < 10; c++) begin
            if (ev[c]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_%s: seen at cycle %0d, none expected", evname(c), cyc);
               end else begin
                  got = exp_q.pop_front();
                  check($sformatf("when_%s(cycle<<32|code)", evname(got.code)),
                        {32'(cyc), 32'(c)}, {32'(got.cyc), 32'(got.code)});
                  if (c == got.code && (c == 3 || c == 7 || c == 8))
                     check($sformatf("data_%s", evname(c)), 64'(evd[c]), 64'(got.data));
               end
            end
         end
         if (mem_wren) check("wr_addr_held", 64'(mem_addr), 64'(exp_waddr));
      end
   end

   task automatic issue(input bit fe, input logic [31:0] fa, input logic [1:0] fs,
                        input bit de, input bit dw, input logic [31:0] da, input logic [1:0] ds,
                        input int busy);
      int t, nxt, budget;
      t = cyc + busy;
      exp_waddr = da;
      if (de && (!fe || !last_d_m)) begin
         nxt = predict(1'b1, dw, t, da, ds);
         if (fe) nxt = predict(1'b0, 1'b0, nxt, fa, fs);
      end else begin
         nxt = predict(1'b0, 1'b0, t, fa, fs);
         if (de) nxt = predict(1'b1, dw, nxt, da, ds);
      end
      wbeat = 0;
      if (busy > 0) mem_busy = 1'b1;
      f_req = fe; f_addr = fa; f_acc_size = fs;
      d_req = de; d_wren = dw; d_addr = da; d_acc_size = ds;
      budget = 0;
      while ((f_req || d_req) && budget < 200) begin
         @(posedge clock); #1;
         budget++;
         if (cyc >= t) mem_busy = 1'b0;
         if (f_ack || f_err) f_req = 1'b0;
         if (d_ack || d_err) d_req = 1'b0;
      end
      if (f_req || d_req) begin
         checks++;
         $display("FAIL handshake_timeout: f_req=%0b d_req=%0b still pending, required ack or err", f_req, d_req);
         f_req = 1'b0; d_req = 1'b0; mem_busy = 1'b0;
      end
      while (cyc < nxt && budget < 400) begin
         @(posedge clock); #1;
         budget++;
      end
   endtask

   task automatic fill_wbuf(input int n);
      wbuf.delete();
      for (int k = 0; k < n; k++) wbuf.push_back($urandom);
   endtask

   function automatic logic [31:0] valid_addr();
      return BASE + 32'(4 * $urandom_range(0, 60));
   endfunction

   function automatic logic [31:0] any_addr();
      case ($urandom_range(0, 9))
         0:       return BASE + 32'(4 * $urandom_range(0, 60)) + 32'($urandom_range(1, 3));
         1:       return BASE - 32'(4 * $urandom_range(1, 8));
         2:       return BASE + 32'(4 * WORDS) - 32'(4 * $urandom_range(1, 20));
         default: return valid_addr();
      endcase
   endfunction

   function automatic logic [140:0] all_outs();
      return {f_ack, f_err, f_rvalid, f_rdata, f_done, d_ack, d_err, d_wready, d_rvalid, d_rdata,
              d_done, mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable};
   endfunction

   initial begin
      int kind, t;
      logic [1:0] fs, ds;
      logic [31:0] fa, da;
      bit dw;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outputs_nonzero", 64'(|all_outs()), 64'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      check("mem_enable_at_release", 64'(mem_enable), 64'd0);
      @(posedge clock); #1;
      check("mem_enable_after_clock", 64'(mem_enable), 64'd1);

      // single write then single read
      wbuf.delete(); wbuf.push_back(32'h27BDFFE8);
      issue(1'b0, '0, 2'd0, 1'b1, 1'b1, BASE, 2'd0, 0);
      issue(1'b0, '0, 2'd0, 1'b1, 1'b0, BASE, 2'd0, 0);

      // 16-word write burst, fetched back
      fill_wbuf(16);
      issue(1'b0, '0, 2'd0, 1'b1, 1'b1, BASE + 32'h40, 2'd3, 0);
      issue(1'b1, BASE + 32'h40, 2'd3, 1'b0, 1'b0, '0, 2'd0, 0);

      // contention: data wins the first tie, fetch wins after a data grant
      issue(1'b1, BASE + 32'h100, 2'd1, 1'b1, 1'b0, BASE + 32'h40, 2'd1, 0);
      issue(1'b0, '0, 2'd0, 1'b1, 1'b0, BASE + 32'h8, 2'd0, 0);
      issue(1'b1, BASE + 32'h44, 2'd1, 1'b1, 1'b0, BASE + 32'h100, 2'd1, 0);

      // rejects
      fill_wbuf(1);
      issue(1'b0, '0, 2'd0, 1'b1, 1'b1, 32'h80020002, 2'd0, 0);
      check("reject_mem_addr_kept", 64'(mem_addr), 64'(last_acc));
      check("reject_no_write", 64'(mem_wren), 64'd0);
      issue(1'b1, 32'h8001FFFC, 2'd0, 1'b0, 1'b0, '0, 2'd0, 0);
      issue(1'b1, BASE + 32'(4 * WORDS) - 32'd16, 2'd2, 1'b0, 1'b0, '0, 2'd0, 0);
      issue(1'b1, BASE + 32'(4 * WORDS) - 32'd16, 2'd1, 1'b0, 1'b0, '0, 2'd0, 0);

      // memory busy stall for 5 cycles
      issue(1'b0, '0, 2'd0, 1'b1, 1'b0, BASE + 32'h40, 2'd0, 5);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         fs = 2'($urandom_range(0, 3));
         ds = 2'($urandom_range(0, 3));
         dw = 1'($urandom_range(0, 1));
         if (kind == 2) begin fa = valid_addr(); da = valid_addr(); end
         else begin fa = any_addr(); da = any_addr(); end
         fill_wbuf(beats(ds));
         issue(kind != 1, fa, fs, kind != 0, dw, da, ds, 0);
      end

      // reset during beat 3 of an 8-word data read
      t = cyc;
      push(t + 1, 5, '0);
      for (int k = 0; k < 4; k++) push(t + LAT + 1 + k, 8, ref_word(16 + k));
      d_req = 1'b1; d_wren = 1'b0; d_addr = BASE + 32'h40; d_acc_size = 2'd2;
      @(posedge clock); #1;
      d_req = 1'b0;
      while (cyc < t + LAT + 4) begin @(posedge clock); #1; end
      @(negedge clock); #1;
      reset_n = 1'b0;
      #1;
      check("midreset_outputs_nonzero", 64'(|all_outs()), 64'd0);
      last_d_m = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("held_reset_outputs_nonzero", 64'(|all_outs()), 64'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("mem_enable_after_rerelease", 64'(mem_enable), 64'd1);
      issue(1'b0, '0, 2'd0, 1'b1, 1'b0, BASE + 32'h40, 2'd0, 0);
      issue(1'b1, BASE + 32'h44, 2'd0, 1'b0, 1'b0, '0, 2'd0, 0);

      repeat (4) @(posedge clock);
      #1;
      check("expected_events_left", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end
endmodule
